// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: state encoding, frame geometry and mode-0 idle levels.
package spi_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned FRAME_BITS = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;

endpackage

// File: rtl/spi_master_if.sv
// Host-side start/done handshake of the SPI master.
interface spi_master_if #(
    parameter int unsigned ADDRW = 7,
    parameter int unsigned width = 8
);
    logic             start;
    logic             rw;
    logic [ADDRW-1:0] addr;
    logic [width-1:0] wdata;
    logic [width-1:0] rdata;
    logic             done;
    logic             busy;

    modport master (output start, rw, addr, wdata, input rdata, done, busy);
    modport slave  (input start, rw, addr, wdata, output rdata, done, busy);
endinterface

// File: rtl/sclk_divider.sv
// sclk generator: toggles every CLKDIV clk cycles while enabled; rise/fall flag the edge that toggles.
module sclk_divider #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    import spi_pkg::*;

    localparam int unsigned CNTW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CNTW-1:0] cnt;
    logic            term;

    assign term = (cnt == CNTW'(CLKDIV - 1));
    // Strobes mark the clk edge at which sclk will toggle, so the master acts on that same edge.
    assign rise = en && term && !sclk;
    assign fall = en && term && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= SCLK_IDLE;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= SCLK_IDLE;
        end else if (term) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= CNTW'(cnt + 1'b1);
        end
    end
endmodule

// File: rtl/shift_reg.sv
// Generic shift register, serial-in/parallel-out, LSB in.
module shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[W-2:0], din};
        end
    end
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one 16-bit {addr, rw, data} frame per start/done handshake.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned width  = 8,
    parameter int unsigned ADDRW  = 7,
    parameter int unsigned CLKDIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.slave  bus,
    output logic         sclk,
    output logic         cs,
    output logic         mosi,
    input  logic         miso
);
    localparam int unsigned CNTW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned IDXW = $clog2(FRAME_BITS);

    if (CLKDIV < 1) begin : g_bad_clkdiv
        $error("spi_master: CLKDIV must be >= 1");
    end
    if (ADDRW + 1 + width != FRAME_BITS) begin : g_bad_frame
        $error("spi_master: ADDRW + 1 + width must equal FRAME_BITS");
    end

    state_t                state;
    logic [CNTW-1:0]       cnt;
    logic [IDXW-1:0]       bit_idx;
    logic [FRAME_BITS-1:0] tx_sr;
    logic                  rw_q;
    logic                  rise;
    logic                  fall;
    logic                  div_en;
    logic                  rx_clr;
    logic                  rx_shift;
    logic [width-1:0]      rx_q;
    logic                  term;

    assign div_en   = (state == SHIFT);
    assign term     = (cnt == CNTW'(CLKDIV - 1));
    assign rx_clr   = (state == IDLE) && bus.start;
    // Only the data phase of a read carries slave data.
    assign rx_shift = rise && (rw_q == RW_READ) && (bit_idx >= IDXW'(FRAME_BITS - width));

    sclk_divider #(.CLKDIV(CLKDIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .sclk  (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    shift_reg #(.W(width)) u_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rx_clr),
        .en    (rx_shift),
        .din   (miso),
        .q     (rx_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            tx_sr     <= '0;
            rw_q      <= RW_WRITE;
            cs        <= CS_IDLE;
            mosi      <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_sr    <= {bus.addr, bus.rw,
                                     (bus.rw == RW_READ) ? {width{1'b0}} : bus.wdata};
                        rw_q     <= bus.rw;
                        mosi     <= bus.addr[ADDRW-1];
                        cs       <= 1'b0;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (term) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= CNTW'(cnt + 1'b1);
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        if (bit_idx == IDXW'(FRAME_BITS - 1)) begin
                            mosi  <= 1'b0;
                            state <= HOLD;
                        end else begin
                            mosi    <= tx_sr[FRAME_BITS-2];
                            tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                            bit_idx <= IDXW'(bit_idx + 1'b1);
                        end
                    end
                end
                HOLD: begin
                    if (term) begin
                        cnt      <= '0;
                        cs       <= CS_IDLE;
                        bus.done <= 1'b1;
                        // Loaded on entry to DONE so rdata is valid alongside the done pulse.
                        if (rw_q == RW_READ) begin
                            bus.rdata <= rx_q;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= CNTW'(cnt + 1'b1);
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
